// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters: IDLE -> EXEC -> RESP.
// Optional grant counters (gnt_cnt port) are built only when ALU_ARB_STATS_EN is defined.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [7:0]            req_op,
    input  logic [2*DATA_W-1:0]   req_a,
    input  logic [2*DATA_W-1:0]   req_b,
    output logic [3:0]            alu_op,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic                  alu_zero,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_id,
    output logic [DATA_W-1:0]     resp_result,
    output logic                  resp_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [2*CNT_W-1:0]    gnt_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state_q;
    logic                rr_ptr_q;
    logic [3:0]          op_q;
    logic [DATA_W-1:0]   a_q, b_q, result_q;
    logic                id_q, zero_q, resp_valid_q;
    logic                any_vld, gnt;

    // Grant is offered only out of reset so a held request is never accepted while rst_n is low.
    always_comb begin
        any_vld   = |req_valid;
        gnt       = (&req_valid) ? rr_ptr_q : req_valid[1];
        req_ready = 2'b00;
        if (rst_n && state_q == IDLE && any_vld)
            req_ready[gnt] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (any_vld) begin
                    op_q     <= gnt ? req_op[7:4] : req_op[3:0];
                    a_q      <= gnt ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
                    b_q      <= gnt ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
                    id_q     <= gnt;
                    rr_ptr_q <= ~gnt;
                    state_q  <= EXEC;
                end
                EXEC: begin
                    result_q     <= alu_result;
                    zero_q       <= alu_zero;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: if (resp_ready) begin
                    resp_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_op      = op_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign resp_valid  = resp_valid_q;
    assign resp_id     = id_q;
    assign resp_result = result_q;
    assign resp_zero   = zero_q;

`ifdef ALU_ARB_STATS_EN
    logic [1:0][CNT_W-1:0] cnt_q;

    // Saturating per-requester grant counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++)
                if (req_ready[i] && cnt_q[i] != {CNT_W{1'b1}})
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
    end

    assign gnt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a local ALU model feeds the DUT, expected
// responses are queued at grant time and compared when the DUT presents them.
module tb_alu_share_arbiter;
    localparam int DW = 32;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      req_valid = 2'b00;
    logic [1:0]      req_ready;
    logic [7:0]      req_op = 8'h00;
    logic [2*DW-1:0] req_a = '0;
    logic [2*DW-1:0] req_b = '0;
    logic [3:0]      alu_op;
    logic [DW-1:0]   alu_a, alu_b, alu_result;
    logic            alu_zero;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic            resp_id;
    logic [DW-1:0]   resp_result;
    logic            resp_zero;
`ifdef ALU_ARB_STATS_EN
    logic [2*CW-1:0] gnt_cnt;
`endif

    typedef struct {
        logic          id;
        logic [DW-1:0] res;
        logic          z;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic rr_m  = 1'b0;
    int   cnt_m [2];

    alu_share_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_zero(resp_zero)
`ifdef ALU_ARB_STATS_EN
        , .gnt_cnt(gnt_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_f(input logic [3:0] op, input logic [DW-1:0] a, b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
            4'b1100: return ~(a | b);
            default: return a ^ b;
        endcase
    endfunction

    assign alu_result = alu_f(alu_op, alu_a, alu_b);
    assign alu_zero   = (alu_result == '0);

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic chk_cnt();
`ifdef ALU_ARB_STATS_EN
        chk("gnt_cnt", gnt_cnt, {CW'(cnt_m[1]), CW'(cnt_m[0])});
`endif
    endtask

    // One full transaction; called just after a posedge with the DUT in IDLE.
    task automatic run_op(input logic [1:0] vld, input logic [3:0] o0, input logic [3:0] o1,
                          input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                          input logic [DW-1:0] a1, input logic [DW-1:0] b1, input int hold);
        logic          g;
        logic [3:0]    og;
        logic [DW-1:0] ag, bg;
        exp_t          e;
        int            n;
        req_valid = vld;
        req_op    = {o1, o0};
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        g  = (vld == 2'b11) ? rr_m : vld[1];
        og = g ? o1 : o0;
        ag = g ? a1 : a0;
        bg = g ? b1 : b0;
        n = 0;
        @(negedge clk);
        while (req_ready == 2'b00 && n < 8) begin
            n++;
            @(negedge clk);
        end
        chk("grant", req_ready, 2'b01 << g);
        e.id  = g;
        e.res = alu_f(og, ag, bg);
        e.z   = (e.res == '0);
        sb.push_back(e);
        rr_m = ~g;
        cnt_m[g]++;
        @(negedge clk);
        chk("exec_op", alu_op, og);
        chk("exec_a", alu_a, ag);
        chk("exec_b", alu_b, bg);
        chk("exec_rdy", req_ready, 0);
        chk("exec_vld", resp_valid, 0);
        @(negedge clk);
        chk("resp_lat", resp_valid, 1);
        chk("resp_rdy", req_ready, 0);
        e = sb.pop_front();
        chk("resp_id", resp_id, e.id);
        chk("resp_res", resp_result, e.res);
        chk("resp_z", resp_zero, e.z);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_v", resp_valid, 1);
            chk("hold_res", resp_result, e.res);
            chk("hold_id", resp_id, e.id);
            chk("hold_rdy", req_ready, 0);
            chk("hold_op", alu_op, og);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        req_valid  = 2'b00;
        chk("post_v", resp_valid, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [3:0] ops [6];
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
        cnt_m = '{0, 0};

        // reset with both requesting
        rst_n = 1'b0;
        req_valid = 2'b11;
        repeat (2) begin
            @(negedge clk);
            chk("rst_rdy", req_ready, 0);
            chk("rst_rv", resp_valid, 0);
            chk("rst_a", alu_a, 0);
            chk("rst_op", alu_op, 0);
        end
        chk_cnt();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = 2'b00;

        // 5 + 7 on req0
        run_op(2'b01, 4'b0010, 4'b0000, 32'd5, 32'd7, 32'd0, 32'd0, 0);

        // both held: order 0,1,0,1 from a fresh reset
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rr_m = 1'b0;
        cnt_m = '{0, 0};
        for (int k = 0; k < 4; k++)
            run_op(2'b11, 4'b0010, 4'b0110, 32'd100 + k, 32'd3, 32'd50, 32'd20 + k, 0);
        chk_cnt();

        // response back-pressure for 4 cycles, both still requesting
        run_op(2'b11, 4'b0110, 4'b0001, 32'h10, 32'h3, 32'hF0, 32'h0F, 4);

        // req1 subtract to zero
        run_op(2'b10, 4'b0000, 4'b0110, 32'd1, 32'd1, 32'd9, 32'd9, 0);

        // reset during EXEC discards the op and rewinds the pointer
        req_valid = 2'b01;
        req_op    = 8'h02;
        req_a     = {32'd0, 32'd1};
        req_b     = {32'd0, 32'd2};
        @(negedge clk);
        chk("r6_grant", req_ready, 2'b01);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rr_m = 1'b0;
        cnt_m = '{0, 0};
        repeat (3) begin
            @(negedge clk);
            chk("r6_noresp", resp_valid, 0);
        end
        chk_cnt();
        @(posedge clk);
        #1;
        run_op(2'b11, 4'b0001, 4'b0010, 32'hA0, 32'h0B, 32'd1, 32'd2, 0);

        // randomised mix
        for (int k = 0; k < 8; k++)
            run_op(2'($urandom_range(1, 3)), ops[$urandom_range(0, 5)], ops[$urandom_range(0, 5)],
                   $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 2));
        chk_cnt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
